imem_boot_loader: RTL and testbench

Boot-time instruction loader sitting directly upstream of `iitk_mini_mips`. It accepts a big-endian byte stream over a valid/ready handshake and assembles 32-bit instruction words. It writes them to consecutive instruction-memory addresses through the CPU's `init_mode` / `write_enable` / `init_address` / `init_instruction` port. It then leaves init mode and releases the CPU reset after a fixed hold.

---
 rtl/imem_boot_loader_if.sv | 30 +++
 rtl/imem_boot_loader.sv | 150 +++++++++++++++
 tb/tb_imem_boot_loader.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/imem_boot_loader_if.sv
// Byte-stream and CPU instruction-memory init bus between the boot loader and its neighbours.
// master drives the load request and byte stream; slave is the loader itself.
interface imem_boot_loader_if #(
  parameter int ADDR_W = 12
);
  logic              start;
  logic [ADDR_W-1:0] word_count;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              init_mode;
  logic              write_enable;
  logic [ADDR_W-1:0] init_address;
  logic [31:0]       init_instruction;
  logic              cpu_reset;
  logic              busy;
  logic              done;

  modport master (
    output start, word_count, byte_valid, byte_data,
    input  byte_ready, init_mode, write_enable, init_address, init_instruction,
           cpu_reset, busy, done
  );

  modport slave (
    input  start, word_count, byte_valid, byte_data,
    output byte_ready, init_mode, write_enable, init_address, init_instruction,
           cpu_reset, busy, done
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader: assembles big-endian bytes into 32-bit words, writes them into the CPU
// instruction memory, then drops init mode and releases CPU reset after a fixed hold.
//
// state     | meaning
// S_IDLE    | after reset, CPU held in reset/init mode, waiting for start
// S_LOAD    | collecting 4 bytes of the current word
// S_WRITE   | single-cycle write of the assembled word
// S_RELEASE | init mode off, CPU reset held for RESET_HOLD cycles
// S_RUN     | CPU running; start reloads
module imem_boot_loader #(
  parameter int ADDR_W     = 12,
  parameter int RESET_HOLD = 4
) (
  input logic               clk,
  input logic               reset,
  imem_boot_loader_if.slave bus
);
  localparam int TW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [TW-1:0] HOLD_INIT = TW'(RESET_HOLD - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_RELEASE, S_RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       asm_q, asm_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              byte_ready_q, byte_ready_d;
  logic              init_mode_q, init_mode_d;
  logic              write_enable_q, write_enable_d;
  logic [ADDR_W-1:0] init_address_q, init_address_d;
  logic [31:0]       init_instruction_q, init_instruction_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] index_inc;

  assign index_inc = index_q + ADDR_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q            <= S_IDLE;
      count_q            <= '0;
      index_q            <= '0;
      byte_cnt_q         <= '0;
      asm_q              <= '0;
      timer_q            <= '0;
      byte_ready_q       <= 1'b0;
      init_mode_q        <= 1'b1;
      write_enable_q     <= 1'b0;
      init_address_q     <= '0;
      init_instruction_q <= '0;
      cpu_reset_q        <= 1'b1;
      busy_q             <= 1'b0;
      done_q             <= 1'b0;
    end else begin
      state_q            <= state_d;
      count_q            <= count_d;
      index_q            <= index_d;
      byte_cnt_q         <= byte_cnt_d;
      asm_q              <= asm_d;
      timer_q            <= timer_d;
      byte_ready_q       <= byte_ready_d;
      init_mode_q        <= init_mode_d;
      write_enable_q     <= write_enable_d;
      init_address_q     <= init_address_d;
      init_instruction_q <= init_instruction_d;
      cpu_reset_q        <= cpu_reset_d;
      busy_q             <= busy_d;
      done_q             <= done_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    count_d            = count_q;
    index_d            = index_q;
    byte_cnt_d         = byte_cnt_q;
    asm_d              = asm_q;
    timer_d            = timer_q;
    write_enable_d     = 1'b0;
    init_address_d     = init_address_q;
    init_instruction_d = init_instruction_q;

    case (state_q)
      S_IDLE, S_RUN: begin
        if (bus.start) begin
          count_d    = bus.word_count;
          index_d    = '0;
          byte_cnt_d = '0;
          if (bus.word_count == '0) begin
            state_d = S_RELEASE;
            timer_d = HOLD_INIT;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (bus.byte_valid && byte_ready_q) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0: asm_d[23:16] = bus.byte_data;
            2'd1: asm_d[15:8]  = bus.byte_data;
            2'd2: asm_d[7:0]   = bus.byte_data;
            default: begin
              // Fourth byte goes straight into the output register, not the assembly buffer.
              state_d            = S_WRITE;
              write_enable_d     = 1'b1;
              init_address_d     = index_q;
              init_instruction_d = {asm_q, bus.byte_data};
            end
          endcase
        end
      end
      S_WRITE: begin
        index_d    = index_inc;
        byte_cnt_d = '0;
        if (index_inc == count_q) begin
          state_d = S_RELEASE;
          timer_d = HOLD_INIT;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_RELEASE: begin
        if (timer_q == '0) state_d = S_RUN;
        else               timer_d = timer_q - TW'(1);
      end
      default: state_d = S_IDLE;
    endcase

    // Registered outputs are decoded from the next state so they line up with it.
    byte_ready_d = (state_d == S_LOAD);
    busy_d       = (state_d == S_LOAD) || (state_d == S_WRITE) || (state_d == S_RELEASE);
    done_d       = (state_d == S_RUN);
    init_mode_d  = !((state_d == S_RELEASE) || (state_d == S_RUN));
    cpu_reset_d  = (state_d != S_RUN);
  end

  assign bus.byte_ready       = byte_ready_q;
  assign bus.init_mode        = init_mode_q;
  assign bus.write_enable     = write_enable_q;
  assign bus.init_address     = init_address_q;
  assign bus.init_instruction = init_instruction_q;
  assign bus.cpu_reset        = cpu_reset_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: program loads, stalls, zero count, reload,
// ignored start and asynchronous reset mid-word.
module tb_imem_boot_loader;
  localparam int ADDR_W     = 12;
  localparam int RESET_HOLD = 4;

  logic clk;
  logic reset;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;
  int   t0     = 0;

  imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_boot_loader #(.ADDR_W(ADDR_W), .RESET_HOLD(RESET_HOLD)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_init_mode"},  32'(bus.init_mode),        1);
    chk({tag, "_cpu_reset"},  32'(bus.cpu_reset),        1);
    chk({tag, "_we"},         32'(bus.write_enable),     0);
    chk({tag, "_addr"},       32'(bus.init_address),     0);
    chk({tag, "_instr"},      bus.init_instruction,      0);
    chk({tag, "_byte_ready"}, 32'(bus.byte_ready),       0);
    chk({tag, "_busy"},       32'(bus.busy),             0);
    chk({tag, "_done"},       32'(bus.done),             0);
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] n);
    bus.start      = 1'b1;
    bus.word_count = n;
    tick;
    t0        = cyc;
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    int guard;
    ok    = 1'b0;
    guard = 0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (!ok && guard < 40) begin
      ok = (bus.byte_ready === 1'b1);
      tick;
      guard++;
    end
    if (!ok) chk("byte_accept_timeout", 0, 1);
  endtask

  // Sends one word (optional idle gap before every byte), checks the write,
  // then spends the WRITE cycle and checks the pulse was a single cycle.
  task automatic send_word(input logic [31:0] w, input int gap,
                           input logic [ADDR_W-1:0] addr, input int exp_rel);
    logic [31:0] wv;
    wv = w;
    for (int k = 0; k < 4; k++) begin
      if (gap > 0) begin
        bus.byte_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
          tick;
          chk("stall_we", 32'(bus.write_enable), 0);
        end
      end
      send_byte(wv[31-8*k -: 8]);
    end
    chk("write_we",         32'(bus.write_enable), 1);
    chk("write_addr",       32'(bus.init_address), 32'(addr));
    chk("write_instr",      bus.init_instruction,  wv);
    chk("write_byte_ready", 32'(bus.byte_ready),   0);
    if (exp_rel >= 0) chk("write_cycle", 32'(cyc - t0), 32'(exp_rel));
    bus.byte_valid = 1'b0;
    tick;
    chk("we_one_cycle", 32'(bus.write_enable), 0);
  endtask

  task automatic wait_done;
    int guard;
    guard = 0;
    while (bus.done !== 1'b1 && guard < 30) begin
      tick;
      guard++;
    end
    chk("done",          32'(bus.done),      1);
    chk("run_cpu_reset", 32'(bus.cpu_reset), 0);
    chk("run_init_mode", 32'(bus.init_mode), 0);
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.word_count = '0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    reset          = 1'b0;
    #1 reset = 1'b1;
    #2 chk_reset_vals("por");
    tick;
    tick;
    #2 reset = 1'b0;
    tick;
    chk_reset_vals("idle");

    // A byte offered while idle is not accepted.
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'hAA;
    tick;
    chk("idle_byte_ready", 32'(bus.byte_ready), 0);
    chk("idle_busy",       32'(bus.busy),       0);
    bus.byte_valid = 1'b0;

    // Multiply program, back-to-back stream.
    do_start(3);
    chk("mul_byte_ready", 32'(bus.byte_ready), 1);
    chk("mul_busy",       32'(bus.busy),       1);
    chk("mul_init_mode",  32'(bus.init_mode),  1);
    send_word(32'h20080006, 0, 0, 4);
    send_word(32'h20090007, 0, 1, 9);
    send_word(32'h01095018, 0, 2, 14);
    chk("mul_rel_cycle",     32'(cyc - t0),         15);
    chk("mul_rel_init_mode", 32'(bus.init_mode),    0);
    chk("mul_rel_cpu_reset", 32'(bus.cpu_reset),    1);
    chk("mul_rel_busy",      32'(bus.busy),         1);
    chk("mul_rel_done",      32'(bus.done),         0);
    tick;
    tick;
    tick;
    chk("mul_hold_cpu_reset", 32'(bus.cpu_reset), 1);
    tick;
    chk("mul_run_cycle",     32'(cyc - t0),         19);
    chk("mul_run_cpu_reset", 32'(bus.cpu_reset),    0);
    chk("mul_run_done",      32'(bus.done),         1);
    chk("mul_run_busy",      32'(bus.busy),         0);

    // Reload from RUN with a stalled stream.
    do_start(3);
    chk("stall_reload_cpu_reset", 32'(bus.cpu_reset), 1);
    chk("stall_reload_init_mode", 32'(bus.init_mode), 1);
    chk("stall_reload_done",      32'(bus.done),      0);
    send_word(32'h20080006, 3, 0, -1);
    send_word(32'h20090007, 3, 1, -1);
    send_word(32'h01095018, 3, 2, -1);
    chk("stall_rel_init_mode", 32'(bus.init_mode), 0);
    wait_done;

    // Zero word count goes straight to release.
    do_start(0);
    chk("zero_init_mode",  32'(bus.init_mode),    0);
    chk("zero_cpu_reset",  32'(bus.cpu_reset),    1);
    chk("zero_byte_ready", 32'(bus.byte_ready),   0);
    chk("zero_busy",       32'(bus.busy),         1);
    for (int i = 0; i < RESET_HOLD - 1; i++) begin
      tick;
      chk("zero_we",        32'(bus.write_enable), 0);
      chk("zero_cpu_reset", 32'(bus.cpu_reset),    1);
    end
    tick;
    chk("zero_run_cpu_reset", 32'(bus.cpu_reset), 0);
    chk("zero_run_done",      32'(bus.done),      1);

    // Start pulsed during LOAD must not change count or index.
    do_start(2);
    send_byte(8'h11);
    send_byte(8'h22);
    bus.byte_valid = 1'b0;
    bus.start      = 1'b1;
    bus.word_count = 12'd7;
    tick;
    bus.start = 1'b0;
    chk("ign_busy",       32'(bus.busy),       1);
    chk("ign_byte_ready", 32'(bus.byte_ready), 1);
    send_byte(8'h33);
    send_byte(8'h44);
    chk("ign_we",    32'(bus.write_enable),  1);
    chk("ign_addr",  32'(bus.init_address),  0);
    chk("ign_instr", bus.init_instruction,   32'h11223344);
    bus.byte_valid = 1'b0;
    tick;
    send_word(32'h55667788, 0, 1, -1);
    chk("ign_rel_init_mode", 32'(bus.init_mode), 0);
    wait_done;

    // Reload with a single word.
    do_start(1);
    chk("one_cpu_reset", 32'(bus.cpu_reset), 1);
    chk("one_init_mode", 32'(bus.init_mode), 1);
    chk("one_done",      32'(bus.done),      0);
    send_word(32'hCAFEF00D, 0, 0, -1);
    chk("one_rel_init_mode", 32'(bus.init_mode), 0);
    wait_done;

    // Asynchronous reset in the middle of the second word.
    do_start(2);
    send_word(32'h01020304, 0, 0, -1);
    send_byte(8'hAB);
    send_byte(8'hCD);
    bus.byte_valid = 1'b0;
    #2 reset = 1'b1;
    #1 chk_reset_vals("midrst");
    #1 reset = 1'b0;
    tick;
    chk("midrst_idle_busy", 32'(bus.busy),       0);
    chk("midrst_idle_rdy",  32'(bus.byte_ready), 0);
    do_start(1);
    send_word(32'hDEADBEEF, 0, 0, -1);
    wait_done;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
